// File: rtl/gyro_spi_pkg.sv
// Shared definitions for the SPI gyro responder: register map, command byte
// layout, frame state encoding and the parallel sample record.
package gyro_spi_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [5:0] ADDR_CTRL1    = 6'h20;
  localparam logic [5:0] ADDR_CTRL4    = 6'h23;
  localparam logic [5:0] ADDR_STATUS   = 6'h27;
  localparam logic [5:0] ADDR_OUT_XL   = 6'h28;
  localparam logic [5:0] ADDR_OUT_XH   = 6'h29;
  localparam logic [5:0] ADDR_OUT_YL   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_YH   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_ZL   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_ZH   = 6'h2D;

  localparam int CMD_RW = 7;
  localparam int CMD_MS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_e;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

endpackage

// File: rtl/spi_gyro_responder_if.sv
// SPI pin bundle between the gyro master and this responder.
interface spi_gyro_responder_if;
  logic sclk;
  logic slave_select;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output slave_select, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input slave_select, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus rise/fall detection
// on the synchronized copy; edges are valid for one clk cycle.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: flops use non-blocking assignments so all stages sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_gyro_responder.sv
// Mode-3 SPI slave model of a 3-axis gyro: command decode, small register
// file, tear-free sample loading through a one-deep pending buffer.
module spi_gyro_responder
  import gyro_spi_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST    = 8'h07,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_gyro_responder_if.slave  spi,
  input  logic                 sample_valid,
  input  logic [15:0]          x_sample,
  input  logic [15:0]          y_sample,
  input  logic [15:0]          z_sample,
  output logic [7:0]           ctrl_reg1,
  output logic [7:0]           ctrl_reg4,
  output logic                 reg_wr_stb,
  output logic [5:0]           reg_wr_addr
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  // SCLK idles high; the select copy resets low so a reset mid-frame waits
  // for a fresh select fall instead of treating the held-low pin as one.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi.sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .rst(rst), .din(spi.slave_select),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi.mosi),
    .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [5:0]      addr_q, addr_d;
  logic            rw_q, rw_d;
  logic            ms_q, ms_d;
  logic            miso_q, miso_d;
  logic            wr_stb_q, wr_stb_d;
  logic [5:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      ctrl1_q, ctrl1_d;
  logic [7:0]      ctrl4_q, ctrl4_d;
  logic [5:0][7:0] out_q, out_d;
  logic            zyxda_q, zyxda_d;
  logic            zyxor_q, zyxor_d;
  logic            pend_valid_q, pend_valid_d;
  sample_t         pend_q, pend_d;

  logic [7:0] status_byte;
  logic [7:0] rx_next;
  logic [5:0] addr_next;
  logic       byte_done;
  logic       apply;
  sample_t    apply_smp;
  sample_t    cur_smp;

  assign status_byte = {zyxor_q, 3'b000, zyxda_q, 3'b000};
  assign cur_smp     = '{x: x_sample, y: y_sample, z: z_sample};

  function automatic logic [7:0] rd_mux(input logic [5:0] a, input logic [7:0] c1,
                                        input logic [7:0] c4, input logic [7:0] st,
                                        input logic [5:0][7:0] ob);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      ADDR_WHO_AM_I: v = WHO_AM_I_VAL;
      ADDR_CTRL1:    v = c1;
      ADDR_CTRL4:    v = c4;
      ADDR_STATUS:   v = st;
      ADDR_OUT_XL:   v = ob[0];
      ADDR_OUT_XH:   v = ob[1];
      ADDR_OUT_YL:   v = ob[2];
      ADDR_OUT_YH:   v = ob[3];
      ADDR_OUT_ZL:   v = ob[4];
      ADDR_OUT_ZH:   v = ob[5];
      default:       v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    ms_d         = ms_q;
    miso_d       = miso_q;
    wr_stb_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    ctrl1_d      = ctrl1_q;
    ctrl4_d      = ctrl4_q;
    out_d        = out_q;
    zyxda_d      = zyxda_q;
    zyxor_d      = zyxor_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    apply        = 1'b0;
    apply_smp    = cur_smp;

    rx_next   = {rx_shift_q[6:0], mosi_s};
    addr_next = ms_q ? addr_q + 6'd1 : addr_q;
    byte_done = (bit_cnt_q == 3'd7);

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (byte_done) begin
            rw_d    = rx_next[CMD_RW];
            ms_d    = rx_next[CMD_MS];
            addr_d  = rx_next[5:0];
            state_d = ST_DATA;
            if (rx_next[CMD_RW])
              tx_shift_d = rd_mux(rx_next[5:0], ctrl1_q, ctrl4_q, status_byte, out_q);
          end
        end
      end
      ST_DATA: begin
        if (sclk_fall) begin
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (byte_done) begin
            if (!rw_q) begin
              if (addr_q == ADDR_CTRL1) begin
                ctrl1_d   = rx_next;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
              end else if (addr_q == ADDR_CTRL4) begin
                ctrl4_d   = rx_next;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
              end
            end else if (addr_q == ADDR_OUT_ZH) begin
              zyxda_d = 1'b0;
              zyxor_d = 1'b0;
            end
            addr_d = addr_next;
            if (rw_q)
              tx_shift_d = rd_mux(addr_next, ctrl1_q, ctrl4_q, status_byte, out_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Samples land directly while idle; inside a frame they wait for the
    // select rise so a burst read always sees one consistent sample.
    if (state_q == ST_IDLE) begin
      if (sample_valid) apply = 1'b1;
    end else if (ss_rise) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = 3'd0;
      miso_d       = 1'b0;
      pend_valid_d = 1'b0;
      if (sample_valid) begin
        apply = 1'b1;
      end else if (pend_valid_q) begin
        apply     = 1'b1;
        apply_smp = pend_q;
      end
    end else if (sample_valid) begin
      pend_valid_d = 1'b1;
      pend_d       = cur_smp;
    end

    if (apply) begin
      out_d   = {apply_smp.z[15:8], apply_smp.z[7:0], apply_smp.y[15:8],
                 apply_smp.y[7:0], apply_smp.x[15:8], apply_smp.x[7:0]};
      zyxor_d = zyxor_q | zyxda_q;
      zyxda_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'h00;
      tx_shift_q   <= 8'h00;
      addr_q       <= 6'd0;
      rw_q         <= 1'b0;
      ms_q         <= 1'b0;
      miso_q       <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= 6'd0;
      ctrl1_q      <= CTRL1_RST;
      ctrl4_q      <= 8'h00;
      // NOTE: the OUT register array is reset because a read before the first sample must return zeros.
      out_q        <= '0;
      zyxda_q      <= 1'b0;
      zyxor_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      ms_q         <= ms_d;
      miso_q       <= miso_d;
      wr_stb_q     <= wr_stb_d;
      wr_addr_q    <= wr_addr_d;
      ctrl1_q      <= ctrl1_d;
      ctrl4_q      <= ctrl4_d;
      out_q        <= out_d;
      zyxda_q      <= zyxda_d;
      zyxor_q      <= zyxor_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = (state_q != ST_IDLE);
  assign ctrl_reg1   = ctrl1_q;
  assign ctrl_reg4   = ctrl4_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// Directed bench for spi_gyro_responder: acts as a mode-3 SPI master and
// compares returned bytes and side-band outputs against hand-computed values.
module tb_spi_gyro_responder;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [15:0] x_sample, y_sample, z_sample;
  logic [7:0]  ctrl_reg1, ctrl_reg4;
  logic        reg_wr_stb;
  logic [5:0]  reg_wr_addr;

  spi_gyro_responder_if spi ();

  spi_gyro_responder dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .sample_valid (sample_valid),
    .x_sample     (x_sample),
    .y_sample     (y_sample),
    .z_sample     (z_sample),
    .ctrl_reg1    (ctrl_reg1),
    .ctrl_reg4    (ctrl_reg4),
    .reg_wr_stb   (reg_wr_stb),
    .reg_wr_addr  (reg_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts cycles with reg_wr_stb high and remembers the address.
  int         stb_cycles = 0;
  logic [5:0] stb_addr   = 6'd0;
  always @(posedge clk) begin
    if (reg_wr_stb) begin
      stb_cycles <= stb_cycles + 1;
      stb_addr   <= reg_wr_addr;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic half_bit();
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_low();
    spi.slave_select = 1'b0;
    half_bit();
  endtask

  task automatic ss_high();
    half_bit();
    spi.slave_select = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Shifts nbits of tx MSB first; miso is captured on each SCLK rise.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic miso_seen);
    rx        = 8'h00;
    miso_seen = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi.sclk = 1'b0;
      spi.mosi = tx[i];
      half_bit();
      spi.sclk = 1'b1;
      rx[i]     = spi.miso;
      miso_seen = miso_seen | spi.miso;
      half_bit();
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    x_sample     = x;
    y_sample     = y;
    z_sample     = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Single-register read frame: command byte then one data byte.
  task automatic read_reg(input logic [7:0] cmd, output logic [7:0] val);
    logic [7:0] rx;
    logic       seen;
    ss_low();
    xfer(cmd, 8, rx, seen);
    xfer(8'h00, 8, val, seen);
    ss_high();
  endtask

  logic [7:0] rx, rx0, rx1;
  logic       seen, oe_mid;
  int         stb_base;
  logic [7:0] exp_burst [6];

  initial begin
    exp_burst = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
    rst              = 1'b1;
    spi.sclk         = 1'b1;
    spi.slave_select = 1'b1;
    spi.mosi         = 1'b0;
    sample_valid     = 1'b0;
    x_sample         = 16'h0;
    y_sample         = 16'h0;
    z_sample         = 16'h0;
    repeat (4) @(negedge clk);
    check("rst_ctrl1", ctrl_reg1, 8'h07);
    check("rst_ctrl4", ctrl_reg4, 8'h00);
    check("rst_miso", spi.miso, 1'b0);
    check("rst_miso_oe", spi.miso_oe, 1'b0);
    check("rst_wr_stb", reg_wr_stb, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 6'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Identity read
    stb_base = stb_cycles;
    ss_low();
    oe_mid = spi.miso_oe;
    xfer(8'h8F, 8, rx, seen);
    check("id_cmd_miso_zero", seen, 1'b0);
    xfer(8'h00, 8, rx, seen);
    ss_high();
    check("id_who_am_i", rx, 8'hD3);
    check("id_miso_oe_in_frame", oe_mid, 1'b1);
    check("id_miso_oe_after", spi.miso_oe, 1'b0);
    check("id_no_strobe", stb_cycles - stb_base, 0);

    // Setup write to CTRL_REG1, then ignored write to STATUS
    stb_base = stb_cycles;
    ss_low();
    xfer(8'h20, 8, rx, seen);
    xfer(8'h0F, 8, rx, seen);
    ss_high();
    check("wr_ctrl1", ctrl_reg1, 8'h0F);
    check("wr_ctrl1_stb_cycles", stb_cycles - stb_base, 1);
    check("wr_ctrl1_stb_addr", stb_addr, 6'h20);
    stb_base = stb_cycles;
    ss_low();
    xfer(8'h27, 8, rx, seen);
    xfer(8'hFF, 8, rx, seen);
    ss_high();
    check("wr_status_no_stb", stb_cycles - stb_base, 0);
    read_reg(8'hA7, rx);
    check("status_unchanged", rx, 8'h00);

    // Burst read of all six OUT registers
    pulse_sample(16'h1234, 16'hABCD, 16'h8001);
    read_reg(8'hA7, rx);
    check("status_after_sample", rx, 8'h08);
    ss_low();
    xfer(8'hE8, 8, rx, seen);
    for (int i = 0; i < 6; i++) begin
      xfer(8'h00, 8, rx, seen);
      check($sformatf("burst_byte%0d", i), rx, exp_burst[i]);
    end
    ss_high();
    read_reg(8'hA7, rx);
    check("status_cleared", rx, 8'h00);

    // Tear protection and overrun
    pulse_sample(16'h1111, 16'h3333, 16'h4444);
    ss_low();
    xfer(8'hE8, 8, rx, seen);
    xfer(8'h00, 8, rx0, seen);
    pulse_sample(16'h2222, 16'h5555, 16'h6666);
    xfer(8'h00, 8, rx1, seen);
    ss_high();
    check("tear_xl", rx0, 8'h11);
    check("tear_xh", rx1, 8'h11);
    ss_low();
    xfer(8'hE8, 8, rx, seen);
    xfer(8'h00, 8, rx0, seen);
    xfer(8'h00, 8, rx1, seen);
    ss_high();
    check("pending_xl", rx0, 8'h22);
    check("pending_xh", rx1, 8'h22);
    read_reg(8'hA7, rx);
    check("status_overrun", rx, 8'h88);

    // Repeated read without auto-increment holds the address
    ss_low();
    xfer(8'h8F, 8, rx, seen);
    xfer(8'h00, 8, rx0, seen);
    xfer(8'h00, 8, rx1, seen);
    ss_high();
    check("hold_addr_b0", rx0, 8'hD3);
    check("hold_addr_b1", rx1, 8'hD3);

    // Address wrap 0x3F -> 0x00
    ss_low();
    xfer(8'hFF, 8, rx, seen);
    xfer(8'h00, 8, rx0, seen);
    xfer(8'h00, 8, rx1, seen);
    ss_high();
    check("wrap_3f", rx0, 8'h00);
    check("wrap_00", rx1, 8'h00);

    // Aborted write: partial byte is discarded
    stb_base = stb_cycles;
    ss_low();
    xfer(8'h20, 8, rx, seen);
    xfer(8'hAA, 5, rx, seen);
    ss_high();
    check("abort_ctrl1", ctrl_reg1, 8'h0F);
    check("abort_no_stb", stb_cycles - stb_base, 0);

    // CTRL_REG4 write
    stb_base = stb_cycles;
    ss_low();
    xfer(8'h23, 8, rx, seen);
    xfer(8'h5A, 8, rx, seen);
    ss_high();
    check("wr_ctrl4", ctrl_reg4, 8'h5A);
    check("wr_ctrl4_stb_cycles", stb_cycles - stb_base, 1);
    check("wr_ctrl4_stb_addr", stb_addr, 6'h23);

    // Reset mid-frame during the data byte of a CTRL_REG4 write
    ss_low();
    xfer(8'h23, 8, rx, seen);
    xfer(8'hC3, 4, rx, seen);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl4", ctrl_reg4, 8'h00);
    check("midrst_ctrl1", ctrl_reg1, 8'h07);
    check("midrst_miso", spi.miso, 1'b0);
    check("midrst_miso_oe", spi.miso_oe, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    half_bit();
    spi.sclk = 1'b1;
    ss_high();
    check("midrst_ctrl4_after", ctrl_reg4, 8'h00);
    read_reg(8'h8F, rx);
    check("midrst_who_am_i", rx, 8'hD3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
- SPI slave model of the 3-axis gyro that the gyro SPI master talks to.
- Mode 3: SCLK idles high. Slave samples MOSI on the SCLK rising edge and drives MISO on the SCLK falling edge. Bytes are MSB first, framed by active-low slave select.
- Decodes the first byte of each frame as the command: bit7 = read, bit6 = multi-byte auto-increment, bits[5:0] = register address.
- Serves a small register file whose output registers are loaded from a parallel sample port. Used as the on-board loopback target and as the bench model for the master.

Parameters:
- WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F.
- CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20).
- SYNC_STAGES, 2, synchronizer depth on sclk, ss and mosi (legal values 2–3).

Ports:
- clk  in  1  system clock; must run at least 8x the SCLK rate.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from the master (asynchronous).
- slave_select  in  1  active-low frame select (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- miso  out  1  slave-out data.
- miso_oe  out  1  high while slave_select is low (synchronized); external tristate enable.
- sample_valid  in  1  one-cycle strobe: load x/y/z sample.
- x_sample, y_sample, z_sample  in  16 each  signed axis samples.
- ctrl_reg1  out  8  current CTRL_REG1 value.
- ctrl_reg4  out  8  current CTRL_REG4 value.
- reg_wr_stb  out  1  one-cycle pulse when a writable register is written.
- reg_wr_addr  out  6  address of that write.

Behaviour:
- Reset values:
  - miso = 0, miso_oe = 0, reg_wr_stb = 0, reg_wr_addr = 0.
  - ctrl_reg1 = CTRL1_RST, ctrl_reg4 = 0.
  - OUT registers = 0, STATUS = 0, state = IDLE, pending sample cleared.
- Input conditioning:
  - sclk, slave_select and mosi each pass through SYNC_STAGES flops.
  - Rise/fall events are detected on the synchronized copies.
  - An event is acted on SYNC_STAGES+1 clk cycles after the pin transition.
- Register map (anything not listed reads 0x00; writes to unlisted or read-only addresses are ignored with no reg_wr_stb):
  - 0x0F WHO_AM_I, read-only.
  - 0x20 CTRL_REG1, read/write.
  - 0x23 CTRL_REG4, read/write.
  - 0x27 STATUS, read-only: bit3 = ZYXDA, bit7 = ZYXOR, other bits 0.
  - 0x28–0x2D OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H, read-only.
- State machine: IDLE, CMD, DATA.
  - IDLE -> CMD on a synchronized slave_select fall; bit_cnt is cleared.
  - CMD: each sclk rise shifts mosi into rx_shift. On the 8th rise, latch rw, ms and addr.
    - Read: load tx_shift with reg[addr].
    - Write: nothing further. Go to DATA either way.
  - DATA: each sclk fall drives miso = tx_shift[7], then shifts tx_shift left. Each sclk rise shifts in mosi. On the 8th rise:
    - Write: commit rx byte to reg[addr] if writable, and pulse reg_wr_stb for 1 cycle with reg_wr_addr = addr.
    - Read: apply read side effects.
    - If ms = 1, addr <= addr + 1, wrapping 0x3F -> 0x00.
    - If read, reload tx_shift from the new addr.
    - If ms = 0, addr is held: repeated reads return the same register; repeated writes rewrite it.
  - Any state -> IDLE on a synchronized slave_select rise.
    - A partial byte (bit_cnt not 0) is discarded: no write and no side effect.
    - miso goes to 0 and miso_oe to 0.
- miso timing: miso is 0 during the CMD byte. It changes only on a synchronized sclk fall.
- Sample loading:
  - A sample_valid strobe while IDLE copies x/y/z into OUT registers (L = [7:0], H = [15:8]) in that cycle.
  - If ZYXDA is already 1, ZYXOR is set; ZYXDA is set either way.
  - A sample_valid strobe during a frame is held in a one-deep pending buffer; a newer strobe overwrites it. The buffer is applied on the cycle slave_select rises, so multi-byte reads never tear.
- STATUS clear: completing a read byte of 0x2D clears ZYXDA and ZYXOR.
- Simultaneous events: if a pending apply and a STATUS clear land in the same cycle, the apply wins (ZYXDA = 1).
- Reset mid-frame: everything returns to reset values immediately. The responder resumes at the next slave_select fall.

Decomposition:
- Package gyro_spi_pkg holds:
  - register address constants (ADDR_WHO_AM_I = 6'h0F, ADDR_CTRL1 = 6'h20, ADDR_CTRL4 = 6'h23, ADDR_STATUS = 6'h27, ADDR_OUT_XL = 6'h28 … ADDR_OUT_ZH = 6'h2D);
  - command bit positions (CMD_RW = 7, CMD_MS = 6);
  - the state enum.
- Sub-module spi_sync_edge: parameterized synchronizer plus rise/fall detector, instantiated three times.

Test Plan:
- Identity read: frame bytes 0x8F, 0x00 -> second byte returns 0xD3; miso = 0 throughout the command byte; no reg_wr_stb.
- Setup write: frame 0x20, 0x0F -> ctrl_reg1 = 0x0F; reg_wr_stb pulses once with reg_wr_addr = 0x20. Frame 0x27, 0xFF -> STATUS unchanged, no strobe.
- Burst read: sample_valid with x = 0x1234, y = 0xABCD, z = 0x8001, then frame 0xE8 followed by six 0x00 bytes -> returns 34 12 CD AB 01 80; STATUS read afterwards = 0x00.
- Tear protection and overrun:
  - sample_valid (x = 0x1111) while IDLE, then a second sample_valid (x = 0x2222) mid-burst -> burst still returns 0x1111.
  - After slave_select rises, OUT_X = 0x2222.
  - Reading 0x27 returns 0x88.
- Wrap and abort:
  - Frame 0xFF followed by two read bytes -> returns 0x00 (addr 0x3F), then 0x00 (addr 0x00, wrapped).
  - Write frame 0x20, then 5 bits of 0xAA, then slave_select rises -> ctrl_reg1 unchanged, no strobe.
- Reset mid-frame: assert rst during the data byte of a write to 0x23 -> ctrl_reg4 = 0x00, miso = 0, miso_oe = 0; the next full frame 0x8F, 0x00 returns 0xD3.
